tone_detector: RTL

Receive-side counterpart of tone_gen. It measures the period of an incoming square-wave tone, rising edge to rising edge, in clk cycles. It then matches the period against a fixed note table and reports the detected note index once two consecutive periods agree. It sits behind a ui_in pin in the piano top, so a second board (or loopback from uo_out) can identify which key is sounding.

---
 rtl/piano_pkg.sv | 19 +
 rtl/tone_sync_edge.sv | 25 ++
 rtl/tone_detector.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared note table for the piano tone generator and detector.
// Periods are in clk cycles, index 0 is the lowest-period (highest-pitch) note.
package piano_pkg;

  localparam int NUM_NOTES = 8;
  localparam int NOTE_W    = 8;

  typedef logic [2:0] note_idx_t;

  localparam logic [NUM_NOTES-1:0][NOTE_W-1:0] NOTE_PERIOD = {
    8'd172, 8'd162, 8'd144, 8'd128, 8'd114, 8'd108, 8'd96, 8'd86
  };

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } det_state_t;

endpackage

// File: rtl/tone_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input, plus a one-cycle
// pulse on each synchronized rising edge.
module tone_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      prev_q <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/tone_detector.sv
// Measures the rising-edge-to-rising-edge period of a square-wave tone and
// reports the matching note once two consecutive periods agree.
module tone_detector
  import piano_pkg::*;
#(
  parameter int WIDTH_COUNTER = 10,
  parameter int TIMEOUT       = 1000,
  parameter int TOL           = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     tone_in,
  output note_idx_t                note_idx,
  output logic                     note_valid,
  output logic [WIDTH_COUNTER-1:0] period,
  output logic                     sample_stb,
  output logic                     miss_stb
);

  localparam int PW = WIDTH_COUNTER + 1;
  localparam logic [WIDTH_COUNTER-1:0] TIMEOUT_C = WIDTH_COUNTER'(TIMEOUT);
  localparam logic [WIDTH_COUNTER-1:0] CNT_ONE   = WIDTH_COUNTER'(1);
  localparam logic [PW-1:0]            TOL_W     = PW'(TOL);

  det_state_t               state_q, state_d;
  logic [WIDTH_COUNTER-1:0] cnt_q, cnt_d;
  logic [WIDTH_COUNTER-1:0] period_q, period_d;
  logic                     pend_q, pend_d;
  note_idx_t                cand_idx_q, cand_idx_d;
  logic                     cand_ok_q, cand_ok_d;
  note_idx_t                note_idx_q, note_idx_d;
  logic                     valid_q, valid_d;

  logic                     edge_w;
  logic                     timeout_w;
  logic [NUM_NOTES-1:0]     hit_vec;
  logic                     hit_any;
  note_idx_t                hit_idx;

  tone_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (tone_in),
    .rise_o (edge_w)
  );

  // Distance is taken one bit wider than the period so it can never wrap.
  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_cmp
    logic [PW-1:0] ref_w, per_w, diff_w;
    assign ref_w        = PW'(NOTE_PERIOD[gi]);
    assign per_w        = {1'b0, period_q};
    assign diff_w       = (per_w >= ref_w) ? (per_w - ref_w) : (ref_w - per_w);
    assign hit_vec[gi]  = (diff_w <= TOL_W);
  end

  always_comb begin
    hit_idx = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = note_idx_t'(i);
    end
  end

  assign hit_any   = |hit_vec;
  assign timeout_w = (cnt_q == TIMEOUT_C);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    pend_d     = 1'b0;
    cand_idx_d = cand_idx_q;
    cand_ok_d  = cand_ok_q;
    note_idx_d = note_idx_q;
    valid_d    = valid_q;

    if (!en) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      valid_d    = 1'b0;
      cand_ok_d  = 1'b0;
      cand_idx_d = '0;
    end else begin
      // Score the period captured on the previous cycle.
      if (pend_q) begin
        if (hit_any) begin
          if (cand_ok_q && (cand_idx_q == hit_idx)) begin
            valid_d    = 1'b1;
            note_idx_d = hit_idx;
          end else begin
            cand_idx_d = hit_idx;
            cand_ok_d  = 1'b1;
            valid_d    = 1'b0;
          end
        end else begin
          cand_ok_d = 1'b0;
          valid_d   = 1'b0;
        end
      end

      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (edge_w) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          if (timeout_w) begin
            // A coincident edge is not scored but still restarts the count.
            valid_d    = 1'b0;
            cand_ok_d  = 1'b0;
            cand_idx_d = '0;
            if (edge_w) begin
              cnt_d = CNT_ONE;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else if (edge_w) begin
            period_d = cnt_q;
            pend_d   = 1'b1;
            cnt_d    = CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      pend_q     <= 1'b0;
      cand_idx_q <= '0;
      cand_ok_q  <= 1'b0;
      note_idx_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      pend_q     <= pend_d;
      cand_idx_q <= cand_idx_d;
      cand_ok_q  <= cand_ok_d;
      note_idx_q <= note_idx_d;
      valid_q    <= valid_d;
    end
  end

  assign note_idx   = note_idx_q;
  assign note_valid = valid_q;
  assign period     = period_q;
  assign sample_stb = pend_q & en & hit_any;
  assign miss_stb   = pend_q & en & ~hit_any;

endmodule
